// File: rtl/color_blob_tracker.sv
// color_blob_tracker: per-frame multi-colour blob statistics on a CCD pixel stream.
// Each colour class has a programmable RGB window. Over one frame the block accumulates
// the hit count, first-hit position and bounding box for each colour, then emits a
// one-cycle report after end_frame.
module color_blob_tracker #(
  parameter int PIX_W      = 10,
  parameter int POS_W      = 16,
  parameter int NUM_COLORS = 2,
  parameter int THR_W      = 5,
  parameter int CNT_W      = 20,
  parameter int MIN_PIX    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PIX_W-1:0]                i_R,
  input  logic [PIX_W-1:0]                i_G,
  input  logic [PIX_W-1:0]                i_B,
  input  logic [POS_W-1:0]                i_X_pos,
  input  logic [POS_W-1:0]                i_Y_pos,
  input  logic                            i_pix_valid,
  input  logic                            new_frame,
  input  logic                            end_frame,
  input  logic [NUM_COLORS*6*THR_W-1:0]   i_thresh,
  output logic                            o_valid,
  output logic [NUM_COLORS-1:0]           o_detect,
  output logic [NUM_COLORS-1:0]           o_first_hit,
  output logic [NUM_COLORS*CNT_W-1:0]     o_count,
  output logic [NUM_COLORS*POS_W-1:0]     o_first_x,
  output logic [NUM_COLORS*POS_W-1:0]     o_first_y,
  output logic [NUM_COLORS*4*POS_W-1:0]   o_bbox
);

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;

  logic [CNT_W-1:0] acc_cnt  [NUM_COLORS];
  logic [POS_W-1:0] acc_fx   [NUM_COLORS];
  logic [POS_W-1:0] acc_fy   [NUM_COLORS];
  logic [POS_W-1:0] acc_minx [NUM_COLORS];
  logic [POS_W-1:0] acc_maxx [NUM_COLORS];
  logic [POS_W-1:0] acc_miny [NUM_COLORS];
  logic [POS_W-1:0] acc_maxy [NUM_COLORS];

  logic [CNT_W-1:0] upd_cnt  [NUM_COLORS];
  logic [POS_W-1:0] upd_fx   [NUM_COLORS];
  logic [POS_W-1:0] upd_fy   [NUM_COLORS];
  logic [POS_W-1:0] upd_minx [NUM_COLORS];
  logic [POS_W-1:0] upd_maxx [NUM_COLORS];
  logic [POS_W-1:0] upd_miny [NUM_COLORS];
  logic [POS_W-1:0] upd_maxy [NUM_COLORS];

  logic [CNT_W-1:0] rep_cnt  [NUM_COLORS];
  logic [POS_W-1:0] rep_fx   [NUM_COLORS];
  logic [POS_W-1:0] rep_fy   [NUM_COLORS];
  logic [4*POS_W-1:0] rep_bb [NUM_COLORS];

  logic [NUM_COLORS-1:0] match, hit, first;
  logic accum_en, report;
  logic unused_lsbs;

  function automatic logic in_win(input logic [THR_W-1:0] v,
                                  input logic [THR_W-1:0] lo,
                                  input logic [THR_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Only the component MSBs take part in classification.
  always_comb unused_lsbs = ^{i_R[PIX_W-THR_W-1:0], i_G[PIX_W-THR_W-1:0], i_B[PIX_W-THR_W-1:0]};

  // Classification and next accumulator values. new_frame restarts from zero so a
  // pixel on that cycle belongs to the new frame; the report then uses the old
  // accumulators, otherwise it includes the current pixel.
  always_comb begin
    accum_en = (state == ACCUM) || new_frame;
    report   = (state == ACCUM) && end_frame;
    for (int unsigned c = 0; c < NUM_COLORS; c++) begin
      match[c] = i_pix_valid
        && in_win(i_R[PIX_W-1 -: THR_W], i_thresh[(6*c+0)*THR_W +: THR_W], i_thresh[(6*c+1)*THR_W +: THR_W])
        && in_win(i_G[PIX_W-1 -: THR_W], i_thresh[(6*c+2)*THR_W +: THR_W], i_thresh[(6*c+3)*THR_W +: THR_W])
        && in_win(i_B[PIX_W-1 -: THR_W], i_thresh[(6*c+4)*THR_W +: THR_W], i_thresh[(6*c+5)*THR_W +: THR_W]);
      upd_cnt[c]  = new_frame ? '0 : acc_cnt[c];
      upd_fx[c]   = new_frame ? '0 : acc_fx[c];
      upd_fy[c]   = new_frame ? '0 : acc_fy[c];
      upd_minx[c] = new_frame ? '0 : acc_minx[c];
      upd_maxx[c] = new_frame ? '0 : acc_maxx[c];
      upd_miny[c] = new_frame ? '0 : acc_miny[c];
      upd_maxy[c] = new_frame ? '0 : acc_maxy[c];
      hit[c]   = accum_en && match[c];
      first[c] = hit[c] && (upd_cnt[c] == '0);
      if (first[c]) begin
        upd_cnt[c]  = CNT_W'(1);
        upd_fx[c]   = i_X_pos;
        upd_fy[c]   = i_Y_pos;
        upd_minx[c] = i_X_pos;
        upd_maxx[c] = i_X_pos;
        upd_miny[c] = i_Y_pos;
        upd_maxy[c] = i_Y_pos;
      end else if (hit[c]) begin
        if (upd_cnt[c] != '1) upd_cnt[c] = upd_cnt[c] + CNT_W'(1);
        if (i_X_pos < upd_minx[c]) upd_minx[c] = i_X_pos;
        if (i_X_pos > upd_maxx[c]) upd_maxx[c] = i_X_pos;
        if (i_Y_pos < upd_miny[c]) upd_miny[c] = i_Y_pos;
        if (i_Y_pos > upd_maxy[c]) upd_maxy[c] = i_Y_pos;
      end
      rep_cnt[c] = new_frame ? acc_cnt[c] : upd_cnt[c];
      rep_fx[c]  = new_frame ? acc_fx[c]  : upd_fx[c];
      rep_fy[c]  = new_frame ? acc_fy[c]  : upd_fy[c];
      rep_bb[c]  = new_frame ? {acc_maxy[c], acc_miny[c], acc_maxx[c], acc_minx[c]}
                             : {upd_maxy[c], upd_miny[c], upd_maxx[c], upd_minx[c]};
    end
  end

  // State, accumulators and registered report outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      o_valid     <= 1'b0;
      o_detect    <= '0;
      o_first_hit <= '0;
      o_count     <= '0;
      o_first_x   <= '0;
      o_first_y   <= '0;
      o_bbox      <= '0;
      for (int unsigned c = 0; c < NUM_COLORS; c++) begin
        acc_cnt[c]  <= '0;
        acc_fx[c]   <= '0;
        acc_fy[c]   <= '0;
        acc_minx[c] <= '0;
        acc_maxx[c] <= '0;
        acc_miny[c] <= '0;
        acc_maxy[c] <= '0;
      end
    end else begin
      o_valid     <= report;
      o_first_hit <= first;
      for (int unsigned c = 0; c < NUM_COLORS; c++) begin
        if (report) begin
          o_count[c*CNT_W +: CNT_W]     <= rep_cnt[c];
          o_first_x[c*POS_W +: POS_W]   <= rep_fx[c];
          o_first_y[c*POS_W +: POS_W]   <= rep_fy[c];
          o_bbox[c*4*POS_W +: 4*POS_W]  <= rep_bb[c];
          o_detect[c] <= ({{(32-CNT_W){1'b0}}, rep_cnt[c]} >= 32'(MIN_PIX));
        end
        if (accum_en) begin
          acc_cnt[c]  <= upd_cnt[c];
          acc_fx[c]   <= upd_fx[c];
          acc_fy[c]   <= upd_fy[c];
          acc_minx[c] <= upd_minx[c];
          acc_maxx[c] <= upd_maxx[c];
          acc_miny[c] <= upd_miny[c];
          acc_maxy[c] <= upd_maxy[c];
        end
      end
      case (state)
        IDLE:    if (new_frame) state <= ACCUM;
        ACCUM:   if (end_frame && !new_frame) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Directed bench for color_blob_tracker: a vector table for a basic frame plus
// hand-written sequences for saturation, overlap, abort, back-to-back frames and reset.
module tb_color_blob_tracker;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [9:0]   r = '0, g = '0, b = '0;
  logic [15:0]  x = '0, y = '0;
  logic         pv = 1'b0, nf = 1'b0, ef = 1'b0;
  logic [59:0]  thresh;

  logic         o_valid, o4_valid;
  logic [1:0]   o_detect, o_first_hit, o4_detect, o4_first_hit;
  logic [39:0]  o_count;
  logic [7:0]   o4_count;
  logic [31:0]  o_first_x, o_first_y, o4_first_x, o4_first_y;
  logic [127:0] o_bbox, o4_bbox;

  int n_cmp = 0;
  int n_bad = 0;

  color_blob_tracker #(.PIX_W(10), .POS_W(16), .NUM_COLORS(2), .THR_W(5), .CNT_W(20), .MIN_PIX(16)) dut (
    .clk(clk), .rst(rst), .i_R(r), .i_G(g), .i_B(b), .i_X_pos(x), .i_Y_pos(y),
    .i_pix_valid(pv), .new_frame(nf), .end_frame(ef), .i_thresh(thresh),
    .o_valid(o_valid), .o_detect(o_detect), .o_first_hit(o_first_hit), .o_count(o_count),
    .o_first_x(o_first_x), .o_first_y(o_first_y), .o_bbox(o_bbox));

  color_blob_tracker #(.PIX_W(10), .POS_W(16), .NUM_COLORS(2), .THR_W(5), .CNT_W(4), .MIN_PIX(16)) dut4 (
    .clk(clk), .rst(rst), .i_R(r), .i_G(g), .i_B(b), .i_X_pos(x), .i_Y_pos(y),
    .i_pix_valid(pv), .new_frame(nf), .end_frame(ef), .i_thresh(thresh),
    .o_valid(o4_valid), .o_detect(o4_detect), .o_first_hit(o4_first_hit), .o_count(o4_count),
    .o_first_x(o4_first_x), .o_first_y(o4_first_y), .o_bbox(o4_bbox));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic pv, nf, ef;
    logic [9:0] r, g, b;
    logic [15:0] x, y;
    logic ev;
    logic [1:0] efh;
    logic [19:0] c0, c1;
    logic [15:0] fx0, fy0;
    logic [63:0] bb0;
    logic [1:0] det;
  } vec_t;

  function automatic logic [29:0] win(input logic [4:0] rl, rh, gl, gh, bl, bh);
    return {bh, bl, gh, gl, rh, rl};
  endfunction

  function automatic logic [63:0] bb(input logic [15:0] minx, maxx, miny, maxy);
    return {maxy, miny, maxx, minx};
  endfunction

  function automatic vec_t mkv(input logic pv_, nf_, ef_, input logic [9:0] r_, g_, b_,
                               input logic [15:0] x_, y_, input logic ev_, input logic [1:0] efh_,
                               input logic [19:0] c0_, c1_, input logic [15:0] fx0_, fy0_,
                               input logic [63:0] bb0_, input logic [1:0] det_);
    vec_t v;
    v.pv = pv_; v.nf = nf_; v.ef = ef_; v.r = r_; v.g = g_; v.b = b_; v.x = x_; v.y = y_;
    v.ev = ev_; v.efh = efh_; v.c0 = c0_; v.c1 = c1_; v.fx0 = fx0_; v.fy0 = fy0_;
    v.bb0 = bb0_; v.det = det_;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic pv_, nf_, ef_, input logic [9:0] r_, g_, b_,
                     input logic [15:0] x_, y_);
    pv = pv_; nf = nf_; ef = ef_; r = r_; g = g_; b = b_; x = x_; y = y_;
    @(posedge clk);
    #1;
    pv = 1'b0; nf = 1'b0; ef = 1'b0;
  endtask

  task automatic red(input logic nf_, ef_, input logic [15:0] x_, y_);
    cyc(1'b1, nf_, ef_, 10'h3FF, 10'h000, 10'h000, x_, y_);
  endtask

  task automatic idle(input logic nf_, ef_);
    cyc(1'b0, nf_, ef_, 10'h000, 10'h000, 10'h000, 16'd0, 16'd0);
  endtask

  logic [29:0] w_red, w_green, w_wide;
  vec_t tv [10];

  initial begin
    w_red   = win(5'd17, 5'd31, 5'd0, 5'd5, 5'd0, 5'd5);
    w_green = win(5'd0, 5'd5, 5'd17, 5'd31, 5'd0, 5'd5);
    w_wide  = win(5'd17, 5'd31, 5'd0, 5'd31, 5'd0, 5'd5);
    thresh  = {w_green, w_red};

    tv[0] = mkv(0,1,0, 10'h000,10'h000,10'h000, 16'd0, 16'd0,  0,2'b00, 0,0, 0,0, 64'd0, 2'b00);
    tv[1] = mkv(1,0,0, 10'h3FF,10'h000,10'h000, 16'd10,16'd5,  0,2'b01, 0,0, 0,0, 64'd0, 2'b00);
    tv[2] = mkv(1,0,0, 10'h3FF,10'h000,10'h000, 16'd40,16'd20, 0,2'b00, 0,0, 0,0, 64'd0, 2'b00);
    tv[3] = mkv(0,0,0, 10'h3FF,10'h000,10'h000, 16'd0, 16'd0,  0,2'b00, 0,0, 0,0, 64'd0, 2'b00);
    tv[4] = mkv(1,0,0, 10'h000,10'h3FF,10'h000, 16'd1, 16'd1,  0,2'b10, 0,0, 0,0, 64'd0, 2'b00);
    tv[5] = mkv(1,0,0, 10'h3FF,10'h000,10'h000, 16'd12,16'd30, 0,2'b00, 0,0, 0,0, 64'd0, 2'b00);
    tv[6] = mkv(0,0,1, 10'h000,10'h000,10'h000, 16'd0, 16'd0,  1,2'b00, 20'd3,20'd1, 16'd10,16'd5,
                bb(16'd10,16'd40,16'd5,16'd30), 2'b00);
    tv[7] = mkv(0,0,0, 10'h000,10'h000,10'h000, 16'd0, 16'd0,  0,2'b00, 0,0, 0,0, 64'd0, 2'b00);
    tv[8] = mkv(1,0,0, 10'h3FF,10'h000,10'h000, 16'd3, 16'd3,  0,2'b00, 0,0, 0,0, 64'd0, 2'b00);
    tv[9] = mkv(0,0,1, 10'h000,10'h000,10'h000, 16'd0, 16'd0,  0,2'b00, 0,0, 0,0, 64'd0, 2'b00);

    // reset state
    #12;
    chk("reset_valid", 128'(o_valid), 128'd0);
    chk("reset_count", 128'(o_count), 128'd0);
    chk("reset_bbox", o_bbox, 128'd0);
    chk("reset_first", 128'({o_first_x, o_first_y}), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // basic frame from the vector table
    for (int i = 0; i < 10; i++) begin
      cyc(tv[i].pv, tv[i].nf, tv[i].ef, tv[i].r, tv[i].g, tv[i].b, tv[i].x, tv[i].y);
      chk($sformatf("tv%0d_valid", i), 128'(o_valid), 128'(tv[i].ev));
      chk($sformatf("tv%0d_first_hit", i), 128'(o_first_hit), 128'(tv[i].efh));
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_count0", i), 128'(o_count[19:0]), 128'(tv[i].c0));
        chk($sformatf("tv%0d_count1", i), 128'(o_count[39:20]), 128'(tv[i].c1));
        chk($sformatf("tv%0d_first0", i), 128'({o_first_x[15:0], o_first_y[15:0]}), 128'({tv[i].fx0, tv[i].fy0}));
        chk($sformatf("tv%0d_bbox0", i), 128'(o_bbox[63:0]), 128'(tv[i].bb0));
        chk($sformatf("tv%0d_detect", i), 128'(o_detect), 128'(tv[i].det));
      end
    end

    // 20 green pixels, colour1 only; CNT_W=4 instance saturates at 15
    idle(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 10'h000, 10'h3FF, 10'h000, 16'(100 + i), 16'd50);
      chk("green_first_hit", 128'(o_first_hit), (i == 0) ? 128'd2 : 128'd0);
    end
    idle(1'b0, 1'b1);
    chk("green_valid", 128'(o_valid), 128'd1);
    chk("green_detect", 128'(o_detect), 128'd2);
    chk("green_count1", 128'(o_count[39:20]), 128'd20);
    chk("green_count0", 128'(o_count[19:0]), 128'd0);
    chk("green_first0", 128'({o_first_x[15:0], o_first_y[15:0]}), 128'd0);
    chk("green_bbox0", 128'(o_bbox[63:0]), 128'd0);
    chk("green_first1", 128'({o_first_x[31:16], o_first_y[31:16]}), 128'({16'd100, 16'd50}));
    chk("green_bbox1", 128'(o_bbox[127:64]), 128'(bb(16'd100, 16'd119, 16'd50, 16'd50)));
    chk("sat_valid", 128'(o4_valid), 128'd1);
    chk("sat_count1", 128'(o4_count[7:4]), 128'd15);
    chk("sat_detect", 128'(o4_detect), 128'd0);
    chk("sat_bbox1", 128'(o4_bbox[127:64]), 128'(bb(16'd100, 16'd119, 16'd50, 16'd50)));
    idle(1'b0, 1'b0);
    chk("green_valid_once", 128'(o_valid), 128'd0);

    // one pixel matching both windows
    thresh = {w_wide, w_red};
    idle(1'b1, 1'b0);
    red(1'b0, 1'b0, 16'd7, 16'd8);
    chk("both_first_hit", 128'(o_first_hit), 128'd3);
    idle(1'b0, 1'b1);
    chk("both_valid", 128'(o_valid), 128'd1);
    chk("both_counts", 128'(o_count), 128'({20'd1, 20'd1}));
    chk("both_first", 128'({o_first_x, o_first_y}), 128'({16'd7, 16'd7, 16'd8, 16'd8}));
    thresh = {w_green, w_red};

    // abort: new_frame mid-frame after 5 hits
    idle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) red(1'b0, 1'b0, 16'(i), 16'(i));
    idle(1'b1, 1'b0);
    chk("abort_no_valid", 128'(o_valid), 128'd0);
    red(1'b0, 1'b0, 16'd60, 16'd61);
    chk("abort_first_hit", 128'(o_first_hit), 128'd1);
    red(1'b0, 1'b0, 16'd62, 16'd63);
    idle(1'b0, 1'b1);
    chk("abort_valid", 128'(o_valid), 128'd1);
    chk("abort_count0", 128'(o_count[19:0]), 128'd2);
    chk("abort_bbox0", 128'(o_bbox[63:0]), 128'(bb(16'd60, 16'd62, 16'd61, 16'd63)));
    idle(1'b0, 1'b0);
    chk("abort_valid_once", 128'(o_valid), 128'd0);

    // end_frame + new_frame together with a matching pixel
    idle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) red(1'b0, 1'b0, 16'(20 + i), 16'(20 + i));
    red(1'b1, 1'b1, 16'd1, 16'd2);
    chk("b2b_valid", 128'(o_valid), 128'd1);
    chk("b2b_count0", 128'(o_count[19:0]), 128'd3);
    chk("b2b_first0", 128'({o_first_x[15:0], o_first_y[15:0]}), 128'({16'd20, 16'd20}));
    chk("b2b_first_hit", 128'(o_first_hit), 128'd1);
    idle(1'b0, 1'b1);
    chk("b2b2_valid", 128'(o_valid), 128'd1);
    chk("b2b2_count0", 128'(o_count[19:0]), 128'd1);
    chk("b2b2_first0", 128'({o_first_x[15:0], o_first_y[15:0]}), 128'({16'd1, 16'd2}));
    chk("b2b2_bbox0", 128'(o_bbox[63:0]), 128'(bb(16'd1, 16'd1, 16'd2, 16'd2)));

    // asynchronous reset mid-frame
    idle(1'b1, 1'b0);
    red(1'b0, 1'b0, 16'd5, 16'd5);
    red(1'b0, 1'b0, 16'd6, 16'd6);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_count", 128'(o_count), 128'd0);
    chk("rst_async_outs", 128'({o_valid, o_detect, o_first_hit, o_first_x, o_first_y}), 128'd0);
    chk("rst_async_bbox", o_bbox, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1'b0, 1'b1);
    chk("rst_no_valid", 128'(o_valid), 128'd0);
    chk("rst_count", 128'(o_count), 128'd0);
    chk("rst_bbox", o_bbox, 128'd0);
    idle(1'b0, 1'b0);
    chk("rst_no_valid_late", 128'(o_valid), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
